// File: rtl/cpu_axi_pkg.sv
// cpu_axi_pkg
// Shared AXI constants and the line-fill FSM state type used by the CPU-side
// AXI masters (instruction line-fill engine).
//   fill_state_t    : IDLE -> ADDR -> DATA -> DONE -> IDLE
//   AXI_BURST_INCR  : INCR burst encoding
//   AXI_SIZE_2B     : 2-byte beat size encoding
//   AXI_RESP_OKAY   : OKAY response encoding
//   INST_ARID       : AXI ID used for instruction fetch traffic
package cpu_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] INST_ARID      = 4'd0;

endpackage

// File: rtl/inst_line_fill.sv
// inst_line_fill
// AXI4 read-master line-fill engine for the instruction cache. A miss request
// issues one INCR burst of LINE_WORDS 16-bit beats at the line base address,
// each returned beat is written straight into the cache SRAM, and a one-cycle
// done pulse reports completion.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      miss request handshake, req_addr = missing byte address
//   fill_we/fill_idx/fill_data  SRAM write port (combinational, lands in the beat cycle)
//   done                     one-cycle completion pulse
//   err                      sticky error, cleared when the next request is accepted
//   ar*_m_inf                AXI read address channel (master side)
//   r*_m_inf                 AXI read data channel (master side)
//
// Configuration macro:
//   INST_FILL_RLAST_CHECK_EN  when defined, rlast is checked against the beat
//                             count; an early rlast sets err and ends the line,
//                             a missing rlast on the final beat sets err.
//                             When undefined, rlast is ignored.
module inst_line_fill
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 128,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              fill_we,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [15:0]       fill_data,
    output logic              done,
    output logic              err,
    output logic [3:0]        arid_m_inf,
    output logic [ADDR_W-1:0] araddr_m_inf,
    output logic [6:0]        arlen_m_inf,
    output logic [2:0]        arsize_m_inf,
    output logic [1:0]        arburst_m_inf,
    output logic              arvalid_m_inf,
    input  logic              arready_m_inf,
    input  logic [3:0]        rid_m_inf,
    input  logic [DATA_W-1:0] rdata_m_inf,
    input  logic [1:0]        rresp_m_inf,
    input  logic              rlast_m_inf,
    input  logic              rvalid_m_inf,
    output logic              rready_m_inf
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    // A line is LINE_WORDS 2-byte words, so the byte offset spans 2*LINE_WORDS.
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(2 * LINE_WORDS - 1);

    fill_state_t      state;
    logic [IDX_W-1:0] count;
    logic             beat;
    logic             last_beat;
    logic             line_end;
    logic             beat_err;
    logic             unused_rbits;

    assign arid_m_inf    = INST_ARID;
    assign arlen_m_inf   = 7'(LINE_WORDS - 1);
    assign arsize_m_inf  = AXI_SIZE_2B;
    assign arburst_m_inf = AXI_BURST_INCR;

    // rready is only ever high in DATA, so this is the accepted-beat strobe.
    assign beat      = rready_m_inf & rvalid_m_inf;
    assign last_beat = (count == LAST_IDX);

    assign fill_we   = beat;
    assign fill_idx  = count;
    assign fill_data = beat ? rdata_m_inf[15:0] : 16'h0000;

`ifdef INST_FILL_RLAST_CHECK_EN
    // Early rlast terminates the line; a missing rlast on the final beat is flagged.
    assign line_end = last_beat | rlast_m_inf;
    assign beat_err = (rresp_m_inf != AXI_RESP_OKAY) | (rlast_m_inf ^ last_beat);
`else
    assign line_end = last_beat;
    assign beat_err = (rresp_m_inf != AXI_RESP_OKAY);
`endif

    // Read-channel bits that carry no meaning for this engine.
    assign unused_rbits = ^{rid_m_inf, rdata_m_inf[DATA_W-1:16], rlast_m_inf};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            req_ready     <= 1'b1;
            arvalid_m_inf <= 1'b0;
            rready_m_inf  <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            araddr_m_inf  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        araddr_m_inf  <= req_addr & ~LINE_MASK;
                        err           <= 1'b0;
                        count         <= '0;
                        req_ready     <= 1'b0;
                        arvalid_m_inf <= 1'b1;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (arready_m_inf) begin
                        arvalid_m_inf <= 1'b0;
                        rready_m_inf  <= 1'b1;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        count <= count + 1'b1;
                        if (beat_err) begin
                            err <= 1'b1;
                        end
                        if (line_end) begin
                            rready_m_inf <= 1'b0;
                            done         <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_line_fill.md
# inst_line_fill

AXI4 read-master line-fill engine for the CPU instruction cache. On a cache-miss request it issues one INCR burst on the instruction DRAM read channel (DRAM port 0, `ID=0`), streams every returned beat into the cache SRAM write port, and then reports completion. It sits between the instruction-cache controller and the pseudo instruction DRAM's AXI read address/data channels.

## Interface
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, AXI read-data width; the instruction word is `rdata[15:0]`
- `LINE_WORDS`, 128, 16-bit words per line; power of two, 2..128
- `IDX_W`, $clog2(LINE_WORDS), width of the fill index
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  miss request
- `req_ready`  out  1  engine idle, accepts request
- `req_addr`  in  ADDR_W  byte address of the missing word
- `fill_we`  out  1  cache SRAM write strobe, one per beat
- `fill_idx`  out  IDX_W  word index within the line
- `fill_data`  out  16  instruction word
- `done`  out  1  one-cycle pulse when the line is complete
- `err`  out  1  sticky protocol/response error, cleared by the next accepted request
- `arid_m_inf`  out  4  constant 0
- `araddr_m_inf`  out  ADDR_W  line base address
- `arlen_m_inf`  out  7  constant LINE_WORDS-1
- `arsize_m_inf`  out  3  constant 3'b001
- `arburst_m_inf`  out  2  constant 2'b01 (INCR)
- `arvalid_m_inf`  out  1  address valid
- `arready_m_inf`  in  1  address accepted
- `rid_m_inf`  in  4  ignored
- `rdata_m_inf`  in  DATA_W  read data
- `rresp_m_inf`  in  2  response; nonzero is an error
- `rlast_m_inf`  in  1  last beat
- `rvalid_m_inf`  in  1  data valid
- `rready_m_inf`  out  1  data accepted

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: `req_ready`=1. On `req_valid`, latch `araddr = req_addr & ~(2*LINE_WORDS-1)`, clear `err` and the beat counter, and go to ADDR.
- ADDR: `arvalid`=1 with address stable. On `arready`, go to DATA. `arvalid` never drops before `arready`.
- DATA: `rready`=1. Each `rvalid` beat does the following in the same cycle:
  - `fill_we`=1, `fill_idx`=counter, `fill_data`=`rdata[15:0]`.
  - Counter increments and wraps to 0 after LINE_WORDS-1.
  - `rresp`≠0 sets `err`; the beat is still written.
- The final beat is the one with counter = LINE_WORDS-1. On it, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `req_valid` outside IDLE is ignored because `req_ready`=0. Request and completion never overlap.
- `rvalid` outside DATA is ignored; `rready`=0 there.
- Reset mid-burst: all state returns to IDLE immediately. The outstanding burst is abandoned. The slave is reset with the same `rst`.

## Timing
- Reset values: `req_ready`=1; `arvalid`, `rready`, `fill_we`, `done`, `err` = 0; `araddr`, `fill_idx`, `fill_data` = 0.
- All outputs are registered except `fill_we`, `fill_idx`, `fill_data`. Those three are combinational from `rvalid`, `rdata` and the counter, so SRAM writes land in the beat cycle.
- Request accepted at edge N: `arvalid` is high from N+1.
- `arready` sampled high at edge M: `rready` is high from M+1.
- Last beat at edge K: `done` is high in cycle K+1, and `req_ready` returns at K+2.
- Minimum latency from request to `done` is LINE_WORDS+3 cycles when `arready` and `rvalid` are continuous.
- Stalls: gaps in `rvalid` stall the counter; no beat is lost.

## Configuration
- `INST_FILL_RLAST_CHECK_EN` defined:
  - `rlast` on a beat with counter ≠ LINE_WORDS-1 sets `err` and ends the line (go to DONE).
  - A missing `rlast` on the final beat sets `err`.
- Undefined: `rlast` is ignored, and completion is by beat count only.

## Structure
- The shared package `cpu_axi_pkg` holds:
  - the state enum;
  - `AXI_BURST_INCR`=2'b01;
  - `AXI_SIZE_2B`=3'b001;
  - `AXI_RESP_OKAY`=2'b00;
  - `INST_ARID`=4'd0.
- Single module; no sub-module warranted.

## Test plan
- `req_addr`=0x0000_1234, LINE_WORDS=128, slave with `arready` delayed 3 cycles and 128 back-to-back beats of data=index → `araddr`=0x1200, `arlen`=127, `arsize`=1, `arburst`=1; 128 `fill_we` pulses with idx 0..127 and data 0..127; `done` one cycle after the last beat.
- Same request with random `rvalid` gaps (50%) → identical fill contents; `done` once; `err`=0.
- `rresp`=2'b10 on beat 5 → beat still written; `err`=1 at `done`; the next accepted request clears `err`.
- With `INST_FILL_RLAST_CHECK_EN`, `rlast` asserted on beat 63 → `err`=1 and `done` after beat 63. Without the macro, the same stimulus continues to 128 beats with `err`=0.
- `req_valid` held high through a burst → only one AR handshake until `done`; second request accepted in IDLE.
- `rst` pulsed during beat 40 → `arvalid`, `rready`, `fill_we`, `done` = 0 immediately; `req_ready`=1; a fresh request completes normally.
